sram_image_loader: RTL and testbench



---
 rtl/sram_image_loader.sv | 162 ++++++++++++++++
 tb/tb_sram_image_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_image_loader.sv
// Packs a header/pixel stream into the input-SRAM image layout: per image a
// dimension word followed by N row words, then one terminator word.
module sram_image_loader #(
   parameter logic [11:0] BASE_ADDR = 12'd0,
   parameter logic [15:0] TERM_WORD = 16'h00FF,
   parameter logic [11:0] MAX_ADDR  = 12'd4095
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        err,
   input  logic        hdr_valid,
   output logic        hdr_ready,
   input  logic [4:0]  hdr_dim,
   input  logic        hdr_last,
   input  logic        pix_valid,
   output logic        pix_ready,
   input  logic        pix_bit,
   output logic [11:0] sram_write_address,
   output logic [15:0] sram_write_data,
   output logic        sram_write_enable
);

   typedef enum logic [1:0] {IDLE, HDR, PIX, TERM} state_t;

   state_t      state, state_next;
   logic [12:0] ptr;          // one spare bit so an overflow past MAX_ADDR is visible
   logic [4:0]  dim_q;
   logic        last_q;
   logic [3:0]  col, row;
   logic [15:0] row_word;

   logic [15:0] packed_word, wr_word;
   logic        dim_legal, col_last, row_last, ovf;
   logic        wr_req, wr_fire, abort_req, abort_any;
   logic        begin_load, load_hdr, pix_acc, row_end, term_req;

   assign dim_legal   = (hdr_dim == 5'd10) || (hdr_dim == 5'd12) || (hdr_dim == 5'd16);
   assign packed_word = row_word | (16'(pix_bit) << col);
   assign col_last    = ({1'b0, col} == dim_q - 5'd1);
   assign row_last    = ({1'b0, row} == dim_q - 5'd1);
   assign ovf         = ptr > {1'b0, MAX_ADDR};

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_next = state;
      hdr_ready  = 1'b0;
      pix_ready  = 1'b0;
      wr_req     = 1'b0;
      wr_word    = 16'd0;
      abort_req  = 1'b0;
      begin_load = 1'b0;
      load_hdr   = 1'b0;
      pix_acc    = 1'b0;
      row_end    = 1'b0;
      term_req   = 1'b0;

      case (state)
         IDLE: begin
            // busy is still high during the done cycle, which keeps a start there ignored
            if (start && !busy) begin
               begin_load = 1'b1;
               state_next = HDR;
            end
         end
         HDR: begin
            hdr_ready = 1'b1;
            if (hdr_valid) begin
               if (dim_legal) begin
                  wr_req     = 1'b1;
                  wr_word    = {11'd0, hdr_dim};
                  load_hdr   = 1'b1;
                  state_next = PIX;
               end else begin
                  abort_req  = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         PIX: begin
            pix_ready = 1'b1;
            if (pix_valid) begin
               pix_acc = 1'b1;
               if (col_last) begin
                  wr_req  = 1'b1;
                  wr_word = packed_word;
                  row_end = 1'b1;
                  if (row_last) state_next = last_q ? TERM : HDR;
               end
            end
         end
         TERM: begin
            wr_req     = 1'b1;
            wr_word    = TERM_WORD;
            term_req   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      wr_fire   = wr_req && !ovf;
      abort_any = abort_req || (wr_req && ovf);
      if (abort_any) state_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         busy               <= 1'b0;
         done               <= 1'b0;
         err                <= 1'b0;
         sram_write_enable  <= 1'b0;
         sram_write_address <= 12'd0;
         sram_write_data    <= 16'd0;
         ptr                <= {1'b0, BASE_ADDR};
         dim_q              <= 5'd0;
         last_q             <= 1'b0;
         col                <= 4'd0;
         row                <= 4'd0;
         row_word           <= 16'd0;
      end else begin
         sram_write_enable <= wr_fire;
         done              <= term_req && wr_fire;
         err               <= abort_any;

         if (begin_load)                busy <= 1'b1;
         else if (abort_any || done)    busy <= 1'b0;

         if (begin_load) ptr <= {1'b0, BASE_ADDR};
         if (wr_fire) begin
            sram_write_address <= ptr[11:0];
            sram_write_data    <= wr_word;
            ptr                <= ptr + 13'd1;
         end

         if (load_hdr) begin
            dim_q    <= hdr_dim;
            last_q   <= hdr_last;
            col      <= 4'd0;
            row      <= 4'd0;
            row_word <= 16'd0;
         end else if (pix_acc) begin
            if (row_end) begin
               col      <= 4'd0;
               row      <= row + 4'd1;
               row_word <= 16'd0;
            end else begin
               col      <= col + 4'd1;
               row_word <= packed_word;
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_image_loader.sv
// Randomised bench for sram_image_loader: drives header/pixel streams and
// compares the SRAM write log against a layout model built from the image list.
module tb_sram_image_loader;

   localparam logic [15:0] TERM = 16'h00FF;

   logic        clk = 1'b0;
   logic        reset, start, hdr_valid, hdr_last, pix_valid, pix_bit;
   logic [4:0]  hdr_dim;
   logic        busy, done, err, hdr_ready, pix_ready, sram_write_enable;
   logic [11:0] sram_write_address;
   logic [15:0] sram_write_data;

   int checks = 0;
   int errors = 0;

   logic [11:0] wr_addr_q[$];
   logic [15:0] wr_data_q[$];
   logic [11:0] exp_addr_q[$];
   logic [15:0] exp_data_q[$];
   int          img_dims[$];
   bit          img_bits[$];

   sram_image_loader dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
      .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_dim(hdr_dim), .hdr_last(hdr_last),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_bit(pix_bit),
      .sram_write_address(sram_write_address), .sram_write_data(sram_write_data),
      .sram_write_enable(sram_write_enable)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (sram_write_enable) begin
         wr_addr_q.push_back(sram_write_address);
         wr_data_q.push_back(sram_write_data);
      end
   end

   // Expected layout: header word, N packed rows (column c -> bit c), terminator.
   task automatic build_expected();
      int addr = 0;
      int k = 0;
      exp_addr_q.delete();
      exp_data_q.delete();
      foreach (img_dims[i]) begin
         int n = img_dims[i];
         exp_addr_q.push_back(12'(addr)); exp_data_q.push_back(16'(n)); addr++;
         for (int r = 0; r < n; r++) begin
            int word = 0;
            for (int c = 0; c < n; c++) begin
               if (img_bits[k]) word += (1 << c);
               k++;
            end
            exp_addr_q.push_back(12'(addr)); exp_data_q.push_back(16'(word)); addr++;
         end
      end
      exp_addr_q.push_back(12'(addr)); exp_data_q.push_back(TERM);
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   task automatic check_outputs_zero(input string name);
      checks++;
      if ({busy, done, err, hdr_ready, pix_ready, sram_write_enable} !== 6'b0) begin
         errors++;
         $display("FAIL %s flags: got %b expected 000000", name,
                  {busy, done, err, hdr_ready, pix_ready, sram_write_enable});
      end
      checks++;
      if (sram_write_address !== 12'd0 || sram_write_data !== 16'd0) begin
         errors++;
         $display("FAIL %s sram bus: got addr %0h data %0h expected 0 0", name,
                  sram_write_address, sram_write_data);
      end
   endtask

   task automatic start_pulse();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_after_start: got %b expected 1", busy);
      end
   endtask

   task automatic send_header(input int dim, input bit last);
      int t = 0;
      hdr_valid = 1'b1; hdr_dim = 5'(dim); hdr_last = last;
      while (!hdr_ready && t < 20) begin @(negedge clk); t++; end
      checks++;
      if (t == 20) begin
         errors++;
         $display("FAIL hdr_ready_timeout: got 0 expected 1");
      end
      @(negedge clk);
      hdr_valid = 1'b0;
   endtask

   task automatic send_pixel(input bit b, input int gaps);
      int t = 0;
      for (int g = 0; g < gaps; g++) begin
         pix_valid = 1'b0;
         @(negedge clk);
         checks++;
         if (pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL pix_ready_gap: got %b expected 1", pix_ready);
         end
      end
      pix_valid = 1'b1; pix_bit = b;
      while (!pix_ready && t < 20) begin @(negedge clk); t++; end
      checks++;
      if (t != 0) begin
         errors++;
         $display("FAIL pix_ready_stall: waited %0d cycles expected 0", t);
      end
      @(negedge clk);
      pix_valid = 1'b0;
   endtask

   task automatic wait_done();
      int t = 0;
      while (!done && t < 30) begin @(negedge clk); t++; end
      checks++;
      if (t == 30) begin
         errors++;
         $display("FAIL done_timeout: got 0 expected 1");
      end else begin
         checks++;
         if (sram_write_enable !== 1'b1 || sram_write_data !== TERM ||
             sram_write_address !== exp_addr_q[exp_addr_q.size()-1]) begin
            errors++;
            $display("FAIL done_term_write: got we %b addr %0h data %0h expected 1 %0h %0h",
                     sram_write_enable, sram_write_address, sram_write_data,
                     exp_addr_q[exp_addr_q.size()-1], TERM);
         end
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL after_done: got busy %b done %b expected 0 0", busy, done);
         end
      end
   endtask

   task automatic compare_log(input string name);
      checks++;
      if (wr_addr_q.size() != exp_addr_q.size()) begin
         errors++;
         $display("FAIL %s write_count: got %0d expected %0d", name, wr_addr_q.size(),
                  exp_addr_q.size());
      end else begin
         foreach (exp_addr_q[i]) begin
            checks++;
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
               errors++;
               $display("FAIL %s write%0d: got %0h:%0h expected %0h:%0h", name, i,
                        wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
            end
         end
      end
   endtask

   // pattern 0: (row+col)&1, 1: all ones, 2: random. extra: start pulse and
   // hdr_valid held high while pixels stream.
   task automatic do_load(input string name, input int n_img, input int d0, input int d1,
                          input int pattern, input int gap_pct, input bit extra);
      int k = 0;
      img_dims.delete();
      img_bits.delete();
      img_dims.push_back(d0);
      if (n_img > 1) img_dims.push_back(d1);
      foreach (img_dims[i])
         for (int r = 0; r < img_dims[i]; r++)
            for (int c = 0; c < img_dims[i]; c++)
               case (pattern)
                  0:       img_bits.push_back(bit'((r + c) & 1));
                  1:       img_bits.push_back(1'b1);
                  default: img_bits.push_back(bit'($urandom_range(0, 1)));
               endcase
      build_expected();
      clear_log();
      start_pulse();
      foreach (img_dims[i]) begin
         int n = img_dims[i];
         send_header(n, i == img_dims.size() - 1);
         if (extra) begin hdr_valid = 1'b1; hdr_dim = 5'd10; hdr_last = 1'b0; end
         for (int p = 0; p < n * n; p++) begin
            int gaps = 0;
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) gaps = $urandom_range(1, 3);
            if (extra && p == 7) start = 1'b1;
            send_pixel(img_bits[k], gaps);
            start = 1'b0;
            k++;
         end
         hdr_valid = 1'b0;
      end
      wait_done();
      compare_log(name);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check_outputs_zero("reset");
      reset = 1'b0;
      @(negedge clk);
      check_outputs_zero("idle");
   endtask

   task automatic test_single_10();
      do_load("single10", 1, 10, 0, 0, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      do_load("b2b_10_16", 2, 10, 16, 1, 0, 1'b0);
   endtask

   task automatic test_gaps_12();
      do_load("gaps12", 1, 12, 0, 2, 50, 1'b0);
   endtask

   task automatic test_bad_dim();
      clear_log();
      start_pulse();
      hdr_valid = 1'b1; hdr_dim = 5'd14; hdr_last = 1'b1;
      @(negedge clk);
      hdr_valid = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || sram_write_enable !== 1'b0) begin
         errors++;
         $display("FAIL bad_dim_abort: got err %b busy %b we %b expected 1 0 0",
                  err, busy, sram_write_enable);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || hdr_ready !== 1'b0) begin
         errors++;
         $display("FAIL bad_dim_after: got err %b hdr_ready %b expected 0 0", err, hdr_ready);
      end
      checks++;
      if (wr_addr_q.size() != 0) begin
         errors++;
         $display("FAIL bad_dim_writes: got %0d expected 0", wr_addr_q.size());
      end
      do_load("after_bad_dim", 1, 10, 0, 2, 0, 1'b0);
   endtask

   task automatic test_reset_mid();
      clear_log();
      start_pulse();
      send_header(12, 1'b1);
      for (int p = 0; p < 3 * 12 + 5; p++) send_pixel(bit'($urandom_range(0, 1)), 0);
      reset = 1'b1;
      @(negedge clk);
      check_outputs_zero("reset_mid");
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (wr_addr_q.size() != 4 || hdr_ready !== 1'b0 || pix_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_writes: got %0d writes rdy %b%b expected 4 00",
                  wr_addr_q.size(), hdr_ready, pix_ready);
      end
      do_load("after_reset", 1, 16, 0, 2, 20, 1'b0);
   endtask

   task automatic test_ignored_inputs();
      do_load("ignored", 1, 12, 0, 2, 0, 1'b1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; hdr_valid = 1'b0; hdr_dim = 5'd0; hdr_last = 1'b0;
      pix_valid = 1'b0; pix_bit = 1'b0;
      test_reset();
      test_single_10();
      test_back_to_back();
      test_gaps_12();
      test_bad_dim();
      test_reset_mid();
      test_ignored_inputs();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
